// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control path and the ALU.
package mips_pkg;

  // Opcode field IR[31:26]
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // Function field IR[5:0] for R-type
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;

  // ALU operation encoding
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_NOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  // ALU B operand select
  localparam logic [1:0] SRCB_REGB  = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  // Next-PC select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECUTE,
    S_ALUWB,
    S_BRANCH,
    S_ADDIEXEC,
    S_ADDIWB,
    S_JUMP
  } state_t;

  // Per-state control word; pcWrite/branch are internal, combined into pcEn
  typedef struct packed {
    logic       pcWrite;
    logic       branch;
    logic       irWrite;
    logic       memWrite;
    logic       regWrite;
    logic       iOrD;
    logic       regDst;
    logic       memToReg;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] pcSrc;
    logic [2:0] aluControl;
  } ctrl_t;

endpackage

// File: rtl/mips_mc_controller_if.sv
// Controller <-> datapath bundle: instruction fields and flags in, controls out.
interface mips_mc_controller_if #(parameter int CNT_W = 32);
  logic [5:0]       op;
  logic [5:0]       funct;
  logic             zero;
  logic             memReady;
  logic             pcEn;
  logic             irWrite;
  logic             memWrite;
  logic             regWrite;
  logic             iOrD;
  logic             regDst;
  logic             memToReg;
  logic             aluSrcA;
  logic [1:0]       aluSrcB;
  logic [1:0]       pcSrc;
  logic [2:0]       aluControl;
  logic             retire;
  logic             illegal;
  logic [CNT_W-1:0] instrCount;

  // Controller side
  modport master (
    input  op, funct, zero, memReady,
    output pcEn, irWrite, memWrite, regWrite, iOrD, regDst, memToReg,
           aluSrcA, aluSrcB, pcSrc, aluControl, retire, illegal, instrCount
  );

  // Datapath side
  modport slave (
    output op, funct, zero, memReady,
    input  pcEn, irWrite, memWrite, regWrite, iOrD, regDst, memToReg,
           aluSrcA, aluSrcB, pcSrc, aluControl, retire, illegal, instrCount
  );
endinterface

// File: rtl/mips_mc_controller_alu_decoder.sv
// R-type funct to ALU operation, with a legality flag for unsupported functs.
module alu_decoder
  import mips_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] aluControl,
  output logic       legal
);

  // Pure lookup; unknown functs decode to add but are flagged illegal
  always_comb begin
    aluControl = ALU_ADD;
    legal      = 1'b1;
    case (funct)
      FN_ADD:  aluControl = ALU_ADD;
      FN_SUB:  aluControl = ALU_SUB;
      FN_AND:  aluControl = ALU_AND;
      FN_OR:   aluControl = ALU_OR;
      FN_NOR:  aluControl = ALU_NOR;
      FN_SLT:  aluControl = ALU_SLT;
      default: legal      = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_mc_controller.sv
// Multicycle MIPS control unit: Moore FSM sequencing fetch/decode/execute/
// memory/writeback, with retire/illegal pulses and a retired-instruction count.
module mips_mc_controller
  import mips_pkg::*;
#(
  parameter bit MEM_WAIT_EN = 1'b1,
  parameter int CNT_W       = 32
)(
  input  logic                  clk,
  input  logic                  reset_n,
  mips_mc_controller_if.master  bus
);

  state_t           state, nextState;
  ctrl_t            ctrl;
  logic             memRdy;
  logic [2:0]       decAlu;
  logic             decLegal;
  logic [2:0]       aluCtrlReg;
  logic             isLoad;
  logic             opLegal;
  logic             retireNext, illegalNext;
  logic             retireQ, illegalQ;
  logic [CNT_W-1:0] cntQ;

  // With waiting disabled, memory is assumed to answer in one cycle
  assign memRdy = MEM_WAIT_EN ? bus.memReady : 1'b1;

  alu_decoder u_dec (
    .funct      (bus.funct),
    .aluControl (decAlu),
    .legal      (decLegal)
  );

  // Opcode legality; R-type additionally needs a supported funct
  always_comb begin
    opLegal = 1'b0;
    case (bus.op)
      OP_RTYPE: opLegal = decLegal;
      OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: opLegal = 1'b1;
      default: opLegal = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_FETCH;
    else          state <= nextState;
  end

  // IR fields are only trusted in DECODE; capture what later states need
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      aluCtrlReg <= ALU_ADD;
      isLoad     <= 1'b0;
    end else if (state == S_DECODE) begin
      aluCtrlReg <= decAlu;
      isLoad     <= (bus.op == OP_LW);
    end
  end

  // Next-state logic
  always_comb begin
    nextState = S_FETCH;
    case (state)
      S_FETCH:    nextState = memRdy ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (!opLegal) nextState = S_FETCH;
        else begin
          case (bus.op)
            OP_LW, OP_SW: nextState = S_MEMADR;
            OP_RTYPE:     nextState = S_EXECUTE;
            OP_BEQ:       nextState = S_BRANCH;
            OP_ADDI:      nextState = S_ADDIEXEC;
            OP_J:         nextState = S_JUMP;
            default:      nextState = S_FETCH;
          endcase
        end
      end
      S_MEMADR:   nextState = isLoad ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  nextState = memRdy ? S_MEMWB : S_MEMREAD;
      S_MEMWRITE: nextState = memRdy ? S_FETCH : S_MEMWRITE;
      S_EXECUTE:  nextState = S_ALUWB;
      S_ADDIEXEC: nextState = S_ADDIWB;
      default:    nextState = S_FETCH;
    endcase
  end

  // Moore control word per state; FETCH load enables follow memReady
  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.aluSrcB    = SRCB_FOUR;
        ctrl.aluControl = ALU_ADD;
        ctrl.pcSrc      = PCSRC_ALU;
        ctrl.irWrite    = memRdy;
        ctrl.pcWrite    = memRdy;
      end
      S_DECODE: begin
        ctrl.aluSrcB    = SRCB_IMMSH;
        ctrl.aluControl = ALU_ADD;
      end
      S_MEMADR: begin
        ctrl.aluSrcA    = 1'b1;
        ctrl.aluSrcB    = SRCB_IMM;
        ctrl.aluControl = ALU_ADD;
      end
      S_MEMREAD:  ctrl.iOrD = 1'b1;
      S_MEMWB: begin
        ctrl.memToReg = 1'b1;
        ctrl.regWrite = 1'b1;
      end
      S_MEMWRITE: begin
        ctrl.iOrD     = 1'b1;
        ctrl.memWrite = 1'b1;
      end
      S_EXECUTE: begin
        ctrl.aluSrcA    = 1'b1;
        ctrl.aluSrcB    = SRCB_REGB;
        ctrl.aluControl = aluCtrlReg;
      end
      S_ALUWB: begin
        ctrl.regDst   = 1'b1;
        ctrl.regWrite = 1'b1;
      end
      S_BRANCH: begin
        ctrl.aluSrcA    = 1'b1;
        ctrl.aluSrcB    = SRCB_REGB;
        ctrl.aluControl = ALU_SUB;
        ctrl.pcSrc      = PCSRC_ALUOUT;
        ctrl.branch     = 1'b1;
      end
      S_ADDIEXEC: begin
        ctrl.aluSrcA    = 1'b1;
        ctrl.aluSrcB    = SRCB_IMM;
        ctrl.aluControl = ALU_ADD;
      end
      S_ADDIWB:   ctrl.regWrite = 1'b1;
      S_JUMP: begin
        ctrl.pcSrc   = PCSRC_JUMP;
        ctrl.pcWrite = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

  // Completing states; the pulse appears one cycle later
  assign retireNext  = (state == S_MEMWB) || (state == S_ALUWB) ||
                       (state == S_BRANCH) || (state == S_ADDIWB) ||
                       (state == S_JUMP) || ((state == S_MEMWRITE) && memRdy);
  assign illegalNext = (state == S_DECODE) && !opLegal;

  // Registered pulses and the wrapping retired-instruction counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      retireQ  <= 1'b0;
      illegalQ <= 1'b0;
      cntQ     <= '0;
    end else begin
      retireQ  <= retireNext;
      illegalQ <= illegalNext;
      if (retireNext) cntQ <= cntQ + CNT_W'(1);
    end
  end

  // Write enables are gated by reset so nothing commits while it is held
  assign bus.pcEn       = reset_n & (ctrl.pcWrite | (ctrl.branch & bus.zero));
  assign bus.irWrite    = reset_n & ctrl.irWrite;
  assign bus.memWrite   = reset_n & ctrl.memWrite;
  assign bus.regWrite   = reset_n & ctrl.regWrite;
  assign bus.iOrD       = ctrl.iOrD;
  assign bus.regDst     = ctrl.regDst;
  assign bus.memToReg   = ctrl.memToReg;
  assign bus.aluSrcA    = ctrl.aluSrcA;
  assign bus.aluSrcB    = ctrl.aluSrcB;
  assign bus.pcSrc      = ctrl.pcSrc;
  assign bus.aluControl = ctrl.aluControl;
  assign bus.retire     = retireQ;
  assign bus.illegal    = illegalQ;
  assign bus.instrCount = cntQ;

endmodule

// File: tb/tb_mips_mc_controller.sv
// Directed bench: stimulus pushes expected retire/illegal events into a queue,
// a negedge monitor pops them as the pulses appear.
module tb_mips_mc_controller;
  import mips_pkg::*;

  localparam int CNT_W = 3;

  localparam int K_R    = 0;
  localparam int K_LW   = 1;
  localparam int K_SW   = 2;
  localparam int K_BEQ  = 3;
  localparam int K_ADDI = 4;
  localparam int K_J    = 5;
  localparam int K_ILL  = 6;

  typedef struct {
    bit ill;
    int cnt;
    int len;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   expCount = 0;
  exp_t sb[$];

  mips_mc_controller_if #(.CNT_W(CNT_W)) bus();

  mips_mc_controller #(.MEM_WAIT_EN(1'b1), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Monitor: gap between pulses equals the cycle length of the instruction
  int cyc = 0;
  int last = 0;
  always @(negedge clk) begin
    exp_t e;
    if (!reset_n) begin
      cyc  = 0;
      last = 0;
    end else begin
      if (bus.retire || bus.illegal) begin
        if (sb.size() == 0) begin
          chk("unexpected_pulse", {bus.retire, bus.illegal}, 0);
        end else begin
          e = sb.pop_front();
          chk("pulse_retire",  int'(bus.retire),  int'(!e.ill));
          chk("pulse_illegal", int'(bus.illegal), int'(e.ill));
          chk("instrCount",    int'(bus.instrCount), e.cnt);
          chk("instr_cycles",  cyc - last, e.len);
        end
        last = cyc;
      end
      cyc++;
    end
  end

  function automatic int baseLen(input int kind);
    case (kind)
      K_R, K_SW, K_ADDI: return 4;
      K_LW:              return 5;
      K_BEQ, K_J:        return 3;
      default:           return 2;
    endcase
  endfunction

  // Runs one instruction starting in its first FETCH cycle (called at posedge+1)
  task automatic runInstr(input int kind, input logic [5:0] op, input logic [5:0] fn,
                          input logic z, input int sF, input int sM, input int expAlu);
    exp_t e;
    int len;
    len = baseLen(kind) + sF + sM;
    e.ill = (kind == K_ILL);
    if (!e.ill) expCount = (expCount + 1) % (1 << CNT_W);
    e.cnt = expCount;
    e.len = len;
    sb.push_back(e);
    bus.op = op;
    bus.funct = fn;
    bus.zero = z;
    for (int i = 0; i < len; i++) begin
      bus.memReady = !((i < sF) || ((i >= sF + 3) && (i < sF + 3 + sM)));
      #1;
      if (i < sF) begin
        chk("fetch_stall_irWrite", bus.irWrite, 0);
        chk("fetch_stall_pcEn", bus.pcEn, 0);
      end
      if (i == sF) begin
        chk("fetch_irWrite", bus.irWrite, 1);
        chk("fetch_pcEn", bus.pcEn, 1);
        chk("fetch_aluSrcB", bus.aluSrcB, 1);
      end
      if (i == sF + 1) chk("decode_aluSrcB", bus.aluSrcB, 3);
      case (kind)
        K_R: begin
          if (i == sF + 2) begin
            chk("exec_aluControl", bus.aluControl, expAlu);
            chk("exec_aluSrcA", bus.aluSrcA, 1);
          end
          if (i == sF + 3) begin
            chk("aluwb_regWrite", bus.regWrite, 1);
            chk("aluwb_regDst", bus.regDst, 1);
          end
        end
        K_LW: begin
          if (i >= sF + 3 && i <= sF + 3 + sM) begin
            chk("memread_iOrD", bus.iOrD, 1);
            chk("memread_regWrite", bus.regWrite, 0);
          end
          if (i == sF + 4 + sM) begin
            chk("memwb_regWrite", bus.regWrite, 1);
            chk("memwb_memToReg", bus.memToReg, 1);
            chk("memwb_regDst", bus.regDst, 0);
          end
        end
        K_SW: begin
          if (i >= sF + 3 && i <= sF + 3 + sM) begin
            chk("memwrite_memWrite", bus.memWrite, 1);
            chk("memwrite_iOrD", bus.iOrD, 1);
          end
        end
        K_BEQ: begin
          if (i == sF + 2) begin
            chk("branch_aluControl", bus.aluControl, 1);
            chk("branch_pcSrc", bus.pcSrc, 1);
            chk("branch_pcEn", bus.pcEn, int'(z));
          end
        end
        K_ADDI: begin
          if (i == sF + 2) chk("addiexec_aluSrcB", bus.aluSrcB, 2);
          if (i == sF + 3) begin
            chk("addiwb_regWrite", bus.regWrite, 1);
            chk("addiwb_regDst", bus.regDst, 0);
          end
        end
        K_J: begin
          if (i == sF + 2) begin
            chk("jump_pcSrc", bus.pcSrc, 2);
            chk("jump_pcEn", bus.pcEn, 1);
          end
        end
        default: begin
          chk("illegal_regWrite", bus.regWrite, 0);
          chk("illegal_memWrite", bus.memWrite, 0);
        end
      endcase
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    bus.op = 6'h00;
    bus.funct = 6'h20;
    bus.zero = 1'b0;
    bus.memReady = 1'b1;
    reset_n = 1'b0;
    #2;
    chk("rst_retire", bus.retire, 0);
    chk("rst_illegal", bus.illegal, 0);
    chk("rst_instrCount", bus.instrCount, 0);
    chk("rst_irWrite", bus.irWrite, 0);
    chk("rst_pcEn", bus.pcEn, 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    // Plain R-type add
    runInstr(K_R, OP_RTYPE, FN_ADD, 1'b0, 0, 0, 0);

    // lw aborted by reset while waiting in MEMREAD
    bus.op = OP_LW;
    for (int i = 0; i < 3; i++) begin
      bus.memReady = 1'b1;
      @(posedge clk);
      #1;
    end
    bus.memReady = 1'b0;
    #1 chk("abort_memread_iOrD", bus.iOrD, 1);
    reset_n = 1'b0;
    bus.memReady = 1'b1;
    #1;
    chk("abort_regWrite", bus.regWrite, 0);
    chk("abort_irWrite", bus.irWrite, 0);
    chk("abort_pcEn", bus.pcEn, 0);
    chk("abort_fetch_aluSrcB", bus.aluSrcB, 1);
    chk("abort_iOrD", bus.iOrD, 0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1 chk("abort_hold_regWrite", bus.regWrite, 0);
    end
    expCount = 0;
    reset_n = 1'b1;
    #1 chk("abort_instrCount", bus.instrCount, 0);
    chk("abort_retire", bus.retire, 0);

    runInstr(K_LW,   OP_LW,  6'h00, 1'b0, 0, 2, 0);
    runInstr(K_SW,   OP_SW,  6'h00, 1'b0, 1, 1, 0);
    runInstr(K_BEQ,  OP_BEQ, 6'h00, 1'b1, 0, 0, 1);
    runInstr(K_BEQ,  OP_BEQ, 6'h00, 1'b0, 0, 0, 1);
    runInstr(K_R, OP_RTYPE, FN_SUB, 1'b0, 0, 0, 1);
    runInstr(K_R, OP_RTYPE, FN_AND, 1'b0, 0, 0, 2);
    runInstr(K_R, OP_RTYPE, FN_OR,  1'b0, 0, 0, 3);
    runInstr(K_R, OP_RTYPE, FN_NOR, 1'b0, 0, 0, 4);
    runInstr(K_R, OP_RTYPE, FN_SLT, 1'b0, 0, 0, 5);
    runInstr(K_ADDI, OP_ADDI, 6'h00, 1'b0, 0, 0, 0);
    runInstr(K_J,    OP_J,    6'h00, 1'b1, 0, 0, 0);
    runInstr(K_ILL,  6'h3F,   6'h20, 1'b0, 0, 0, 0);
    runInstr(K_ILL,  OP_RTYPE, 6'h01, 1'b0, 0, 0, 0);
    runInstr(K_R, OP_RTYPE, FN_ADD, 1'b0, 1, 0, 0);

    // Let the final pulse reach the monitor
    @(negedge clk);
    #1;
    chk("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
